// File: rtl/riscv_pkg.sv
// Shared RISC-V encoding constants, request formats, packer kinds and the
// encoder FSM state type used by immediate_encoder and imm_packer.
package riscv_pkg;

    // Major opcodes
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_IMM32  = 7'h1B;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;

    // Request format as carried on req_fmt
    typedef enum logic [1:0] {
        FMT_I  = 2'd0,
        FMT_S  = 2'd1,
        FMT_B  = 2'd2,
        FMT_LI = 2'd3
    } req_fmt_e;

    // Bit layout selected inside the packer
    typedef enum logic [1:0] {
        PK_I = 2'd0,
        PK_S = 2'd1,
        PK_B = 2'd2,
        PK_U = 2'd3
    } pack_kind_e;

    // Encoder sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EMIT1 = 2'd1,
        ST_EMIT2 = 2'd2
    } enc_state_e;

endpackage

// File: rtl/imm_packer.sv
// Purely combinational field packer: places register fields, funct3, opcode
// and the (already range-checked) low 32 immediate bits into a 32-bit
// instruction word according to the selected layout (I, S, B or U).
module imm_packer
    import riscv_pkg::*;
(
    input  pack_kind_e  kind,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word
);

    // Select the bit layout for the requested instruction format
    always_comb begin
        word = 32'd0;
        case (kind)
            PK_I:    word = {imm[11:0], rs1, funct3, rd, opcode};
            PK_S:    word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            PK_B:    word = {imm[12], imm[10:5], rs2, rs1, funct3,
                             imm[4:1], imm[11], opcode};
            PK_U:    word = {imm[31:12], rd, opcode};
            default: word = 32'd0;
        endcase
    end

endmodule

// File: rtl/immediate_encoder.sv
// Immediate encoder: accepts I/S/B/LI requests through a valid/ready handshake,
// range-checks the full-width signed immediate and streams one or two encoded
// instruction words. Illegal requests are accepted and answered by a one-cycle
// err pulse with no word.
// Optional feature macro: IMMENC_LI_EN enables the LI pseudo-op (ADDI, or
// LUI + optional ADDIW). Without it, LI requests are rejected and instr_last
// is constantly 1.
// IMMSIZE is expected to be at least 32.
module immediate_encoder
    import riscv_pkg::*;
#(
    parameter int INSTRSIZE = 32,
    parameter int IMMSIZE   = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_fmt,
    input  logic [6:0]           req_opcode,
    input  logic [2:0]           req_funct3,
    input  logic [4:0]           req_rd,
    input  logic [4:0]           req_rs1,
    input  logic [4:0]           req_rs2,
    input  logic [IMMSIZE-1:0]   req_imm,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [INSTRSIZE-1:0] instr,
    output logic                 instr_last,
    output logic                 err
);

    enc_state_e             state_q, state_d;
    logic [INSTRSIZE-1:0]   instr_q, instr_d;
    logic                   err_q, err_d;

    req_fmt_e               fmt_s;
    logic                   accept_s;
    logic                   hs_s;
    logic                   last_s;
    logic                   fits12_s;
    logic                   fits13_s;
    logic                   legal_s;
    logic                   last0_s;

    pack_kind_e             pk0_kind_s;
    logic [6:0]             pk0_op_s;
    logic [2:0]             pk0_f3_s;
    logic [4:0]             pk0_rd_s;
    logic [4:0]             pk0_rs1_s;
    logic [4:0]             pk0_rs2_s;
    logic [31:0]            pk0_imm_s;
    logic [31:0]            pk0_word_s;

`ifdef IMMENC_LI_EN
    logic                   last_q, last_d;
    logic [INSTRSIZE-1:0]   w2_q, w2_d;
    logic [IMMSIZE-12:0]    li_hi_s;
    logic                   fits32_s;
    logic [19:0]            hi20_s;
    logic [11:0]            lo12_s;
    logic [31:0]            pk1_word_s;
`endif

    assign fmt_s       = req_fmt_e'(req_fmt);
    assign instr_valid = (state_q != ST_IDLE);
    assign instr       = instr_q;
    assign err         = err_q;
    assign hs_s        = instr_valid & instr_ready;

`ifdef IMMENC_LI_EN
    assign last_s      = last_q;
`else
    assign last_s      = 1'b1;
`endif
    assign instr_last  = last_s;

    // Ready when idle, or when the final word leaves in this very cycle
    assign req_ready = rst_n & ((state_q == ST_IDLE) | (hs_s & last_s));
    assign accept_s  = req_valid & req_ready;

    // Full-width sign-extension checks: all bits from the top down to the
    // field's sign bit must agree, so no value is truncated before checking.
    assign fits12_s = (&req_imm[IMMSIZE-1:11]) | ~(|req_imm[IMMSIZE-1:11]);
    assign fits13_s = (&req_imm[IMMSIZE-1:12]) | ~(|req_imm[IMMSIZE-1:12]);

`ifdef IMMENC_LI_EN
    // (imm + 0x800) >> 12 computed without the low bits: adding 0x800 only
    // carries imm[11] into bit 12.
    assign li_hi_s  = {req_imm[IMMSIZE-1], req_imm[IMMSIZE-1:12]}
                      + (IMMSIZE-11)'(req_imm[11]);
    assign fits32_s = (&li_hi_s[IMMSIZE-12:19]) | ~(|li_hi_s[IMMSIZE-12:19]);
    assign hi20_s   = li_hi_s[19:0];
    assign lo12_s   = req_imm[11:0];
`endif

    // Decode the request: legality and the fields of the first word
    always_comb begin
        legal_s    = 1'b0;
        last0_s    = 1'b1;
        pk0_kind_s = PK_I;
        pk0_op_s   = req_opcode;
        pk0_f3_s   = req_funct3;
        pk0_rd_s   = req_rd;
        pk0_rs1_s  = req_rs1;
        pk0_rs2_s  = req_rs2;
        pk0_imm_s  = req_imm[31:0];
        case (fmt_s)
            FMT_I: begin
                legal_s    = fits12_s;
                pk0_kind_s = PK_I;
            end
            FMT_S: begin
                legal_s    = fits12_s;
                pk0_kind_s = PK_S;
            end
            FMT_B: begin
                legal_s    = fits13_s & ~req_imm[0];
                pk0_kind_s = PK_B;
            end
            FMT_LI: begin
`ifdef IMMENC_LI_EN
                pk0_f3_s  = 3'd0;
                pk0_rs1_s = 5'd0;
                pk0_rs2_s = 5'd0;
                if (fits12_s) begin
                    legal_s    = 1'b1;
                    pk0_kind_s = PK_I;
                    pk0_op_s   = OP_IMM;
                end else if (fits32_s) begin
                    legal_s    = 1'b1;
                    pk0_kind_s = PK_U;
                    pk0_op_s   = OP_LUI;
                    pk0_imm_s  = {hi20_s, 12'd0};
                    last0_s    = (lo12_s == 12'd0);
                end else begin
                    legal_s    = 1'b0;
                end
`else
                legal_s = 1'b0;
`endif
            end
            default: legal_s = 1'b0;
        endcase
    end

    imm_packer u_pack0 (
        .kind   (pk0_kind_s),
        .opcode (pk0_op_s),
        .funct3 (pk0_f3_s),
        .rd     (pk0_rd_s),
        .rs1    (pk0_rs1_s),
        .rs2    (pk0_rs2_s),
        .imm    (pk0_imm_s),
        .word   (pk0_word_s)
    );

`ifdef IMMENC_LI_EN
    // Second LI word is always ADDIW rd, rd, lo12
    imm_packer u_pack1 (
        .kind   (PK_I),
        .opcode (OP_IMM32),
        .funct3 (3'd0),
        .rd     (req_rd),
        .rs1    (req_rd),
        .rs2    (5'd0),
        .imm    ({20'd0, lo12_s}),
        .word   (pk1_word_s)
    );
`endif

    // Next-state, next-word and error-pulse logic
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        err_d   = 1'b0;
`ifdef IMMENC_LI_EN
        last_d  = last_q;
        w2_d    = w2_q;
`endif
        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_EMIT1: begin
                if (hs_s) begin
`ifdef IMMENC_LI_EN
                    if (!last_q) begin
                        state_d = ST_EMIT2;
                        instr_d = w2_q;
                        last_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
`else
                    state_d = ST_IDLE;
`endif
                end else begin
                    state_d = ST_EMIT1;
                end
            end
            ST_EMIT2: begin
`ifdef IMMENC_LI_EN
                if (hs_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_EMIT2;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase

        // A newly accepted request overrides the drain decision above
        if (accept_s) begin
            if (legal_s) begin
                state_d = ST_EMIT1;
                instr_d = INSTRSIZE'(pk0_word_s);
`ifdef IMMENC_LI_EN
                last_d  = last0_s;
                w2_d    = INSTRSIZE'(pk1_word_s);
`endif
            end else begin
                err_d = 1'b1;
            end
        end else begin
            err_d = 1'b0;
        end
    end

    // State, output word and error pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            instr_q <= {INSTRSIZE{1'b0}};
            err_q   <= 1'b0;
`ifdef IMMENC_LI_EN
            last_q  <= 1'b0;
            w2_q    <= {INSTRSIZE{1'b0}};
`endif
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            err_q   <= err_d;
`ifdef IMMENC_LI_EN
            last_q  <= last_d;
            w2_q    <= w2_d;
`endif
        end
    end

endmodule

// File: tb/tb_immediate_encoder.sv
// Directed self-checking bench for immediate_encoder. LI expectations follow
// the IMMENC_LI_EN build setting.
module tb_immediate_encoder;
    import riscv_pkg::*;

    localparam int INSTRSIZE = 32;
    localparam int IMMSIZE   = 64;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 req_valid;
    logic                 req_ready;
    logic [1:0]           req_fmt;
    logic [6:0]           req_opcode;
    logic [2:0]           req_funct3;
    logic [4:0]           req_rd;
    logic [4:0]           req_rs1;
    logic [4:0]           req_rs2;
    logic [IMMSIZE-1:0]   req_imm;
    logic                 instr_valid;
    logic                 instr_ready;
    logic [INSTRSIZE-1:0] instr;
    logic                 instr_last;
    logic                 err;

    int n_checks = 0;
    int n_errs   = 0;

    immediate_encoder #(.INSTRSIZE(INSTRSIZE), .IMMSIZE(IMMSIZE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_fmt     (req_fmt),
        .req_opcode  (req_opcode),
        .req_funct3  (req_funct3),
        .req_rd      (req_rd),
        .req_rs1     (req_rs1),
        .req_rs2     (req_rs2),
        .req_imm     (req_imm),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_last  (instr_last),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input string tag, input logic [1:0] fmt, input logic [6:0] op,
                        input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [63:0] imm);
        req_fmt    = fmt;
        req_opcode = op;
        req_funct3 = f3;
        req_rd     = rd;
        req_rs1    = rs1;
        req_rs2    = rs2;
        req_imm    = imm;
        req_valid  = 1'b1;
        #1;
        check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic expect_word(input string tag, input logic [31:0] w, input logic last,
                               input int stall);
        for (int i = 0; i < stall; i++) begin
            check({tag, "_stall_valid"}, 64'(instr_valid), 64'd1);
            check({tag, "_stall_instr"}, 64'(instr), 64'(w));
            check({tag, "_stall_last"}, 64'(instr_last), 64'(last));
            tick();
        end
        check({tag, "_valid"}, 64'(instr_valid), 64'd1);
        check({tag, "_instr"}, 64'(instr), 64'(w));
        check({tag, "_last"}, 64'(instr_last), 64'(last));
        check({tag, "_err"}, 64'(err), 64'd0);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
    endtask

    task automatic expect_err(input string tag);
        check({tag, "_err"}, 64'(err), 64'd1);
        check({tag, "_novalid"}, 64'(instr_valid), 64'd0);
        tick();
        check({tag, "_err_drop"}, 64'(err), 64'd0);
        check({tag, "_novalid2"}, 64'(instr_valid), 64'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_fmt     = 2'd0;
        req_opcode  = 7'd0;
        req_funct3  = 3'd0;
        req_rd      = 5'd0;
        req_rs1     = 5'd0;
        req_rs2     = 5'd0;
        req_imm     = 64'd0;
        instr_ready = 1'b0;

        // Reset state
        #12;
        req_valid = 1'b1;
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_instr", 64'(instr), 64'd0);
        check("rst_err", 64'(err), 64'd0);
`ifdef IMMENC_LI_EN
        check("rst_last", 64'(instr_last), 64'd0);
`endif
        req_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check("rel_req_ready", 64'(req_ready), 64'd1);
        tick();

        // I / S / B encodings
        send("i_basic", FMT_I, OP_IMM, 3'd0, 5'd14, 5'd1, 5'd0, -64'sd50);
        expect_word("i_basic", 32'hFCE08713, 1'b1, 0);
        send("s_basic", FMT_S, OP_STORE, 3'd2, 5'd0, 5'd2, 5'd14, -64'sd50);
        expect_word("s_basic", 32'hFCE12723, 1'b1, 2);
        send("b_basic", FMT_B, OP_BRANCH, 3'd0, 5'd0, 5'd19, 5'd10, -64'sd100);
        expect_word("b_basic", 32'hF8A98EE3, 1'b1, 0);

        // Range boundaries
        send("i_min", FMT_I, OP_IMM, 3'd0, 5'd14, 5'd1, 5'd0, -64'sd2048);
        expect_word("i_min", 32'h80008713, 1'b1, 0);
        send("i_max", FMT_I, OP_IMM, 3'd0, 5'd14, 5'd1, 5'd0, 64'sd2047);
        expect_word("i_max", 32'h7FF08713, 1'b1, 0);
        send("i_2048", FMT_I, OP_IMM, 3'd0, 5'd14, 5'd1, 5'd0, 64'sd2048);
        expect_err("i_2048");
        send("i_wide", FMT_I, OP_IMM, 3'd0, 5'd14, 5'd1, 5'd0, 64'h0000_0001_0000_0000);
        expect_err("i_wide");
        send("s_neg_wide", FMT_S, OP_STORE, 3'd2, 5'd0, 5'd2, 5'd14, 64'hFFFF_FFFF_0000_0000);
        expect_err("s_neg_wide");
        send("b_odd", FMT_B, OP_BRANCH, 3'd0, 5'd0, 5'd19, 5'd10, 64'sd7);
        expect_err("b_odd");
        send("b_max", FMT_B, OP_BRANCH, 3'd0, 5'd0, 5'd19, 5'd10, 64'sd4094);
        expect_word("b_max", 32'h7EA98FE3, 1'b1, 0);
        send("b_4096", FMT_B, OP_BRANCH, 3'd0, 5'd0, 5'd19, 5'd10, 64'sd4096);
        expect_err("b_4096");

        // LI pseudo-op
`ifdef IMMENC_LI_EN
        send("li_two", FMT_LI, 7'd0, 3'd0, 5'd5, 5'd0, 5'd0, 64'h1234_5FFF);
        expect_word("li_lui", 32'h123462B7, 1'b0, 3);
        expect_word("li_addiw", 32'hFFF2829B, 1'b1, 0);
        check("li_done", 64'(instr_valid), 64'd0);
        send("li_ovf", FMT_LI, 7'd0, 3'd0, 5'd5, 5'd0, 5'd0, 64'h7FFF_F800);
        expect_err("li_ovf");
        send("li_edge", FMT_LI, 7'd0, 3'd0, 5'd5, 5'd0, 5'd0, 64'h7FFF_F7FF);
        expect_word("li_edge_lui", 32'h7FFFF2B7, 1'b0, 0);
        expect_word("li_edge_addiw", 32'h7FF2829B, 1'b1, 0);
        send("li_small", FMT_LI, 7'd0, 3'd0, 5'd5, 5'd0, 5'd0, -64'sd5);
        expect_word("li_small", 32'hFFB00293, 1'b1, 0);
        send("li_luionly", FMT_LI, 7'd0, 3'd0, 5'd5, 5'd0, 5'd0, 64'h1234_5000);
        expect_word("li_luionly", 32'h123452B7, 1'b1, 0);
        check("li_luionly_done", 64'(instr_valid), 64'd0);
        send("li_wide", FMT_LI, 7'd0, 3'd0, 5'd5, 5'd0, 5'd0, 64'h0000_0001_0000_0000);
        expect_err("li_wide");
`else
        send("li_off", FMT_LI, 7'd0, 3'd0, 5'd5, 5'd0, 5'd0, 64'h1234_5FFF);
        expect_err("li_off");
`endif

        // Reset asserted while a word is pending
`ifdef IMMENC_LI_EN
        send("mid_rst", FMT_LI, 7'd0, 3'd0, 5'd5, 5'd0, 5'd0, 64'h1234_5FFF);
        check("mid_rst_lui", 64'(instr), 64'h0000_0000_1234_62B7);
`else
        send("mid_rst", FMT_I, OP_IMM, 3'd0, 5'd14, 5'd1, 5'd0, -64'sd50);
        check("mid_rst_word", 64'(instr), 64'h0000_0000_FCE0_8713);
`endif
        check("mid_rst_pre_valid", 64'(instr_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(instr_valid), 64'd0);
        check("mid_rst_instr", 64'(instr), 64'd0);
        check("mid_rst_ready", 64'(req_ready), 64'd0);
`ifdef IMMENC_LI_EN
        check("mid_rst_last", 64'(instr_last), 64'd0);
`endif
        tick();
        rst_n = 1'b1;
        #1;
        check("mid_rel_ready", 64'(req_ready), 64'd1);
        instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_rel_noword", 64'(instr_valid), 64'd0);
        end
        instr_ready = 1'b0;

        // Back-to-back I requests with the consumer always ready
        instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_fmt    = FMT_I;
            req_opcode = OP_IMM;
            req_funct3 = 3'd0;
            req_rd     = 5'(k + 1);
            req_rs1    = 5'd1;
            req_rs2    = 5'd0;
            req_imm    = -64'sd50;
            req_valid  = 1'b1;
            #1;
            check("b2b_req_ready", 64'(req_ready), 64'd1);
            tick();
            check("b2b_valid", 64'(instr_valid), 64'd1);
            check("b2b_instr", 64'(instr), 64'(32'hFCE08013 | (32'(k + 1) << 7)));
        end
        req_valid = 1'b0;
        tick();
        check("b2b_drain", 64'(instr_valid), 64'd0);
        instr_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
